// File: rtl/demux4_sched_pkg.sv
// Shared types and helpers for the demux4_sched sequencer.
// Optional counters are enabled with DEMUX4_SCHED_STATS_EN.
package demux4_sched_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_RR   = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // First enabled channel strictly after ptr, wrapping; ptr itself is last resort.
  function automatic logic [1:0] next_enabled(
    input logic [1:0] ptr,
    input logic [3:0] mask
  );
    logic [1:0] idx;
    logic [1:0] pick;
    pick = ptr;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = ptr + 2'(i);
      if (mask[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/demux4_rr_pick.sv
// Rotating-priority picker: grant is the next enabled channel after ptr.
module demux4_rr_pick
  import demux4_sched_pkg::*;
(
  input  logic [1:0] ptr_i,
  input  logic [3:0] mask_i,
  output logic [1:0] grant_o,
  output logic       any_o
);

  assign grant_o = next_enabled(ptr_i, mask_i);
  assign any_o   = |mask_i;

endmodule

// File: rtl/demux4_sched.sv
// 1:4 demux sequencer, addressed or round-robin routing.
// DEMUX4_SCHED_STATS_EN adds saturating per-channel delivery counters.
module demux4_sched
  import demux4_sched_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [3:0]        ch_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_dest,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic              drop
`ifdef DEMUX4_SCHED_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [NUM_CH*CNT_W-1:0] ch_count
`endif
);

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        vld_q, vld_d;
  logic [1:0]        rr_q, rr_d;
  logic              drop_q, drop_d;

  logic       hold, fire, rr, route_ok, load;
  logic       dropped, accept;
  logic [1:0] grant, dest;
  logic       any_en;

  demux4_rr_pick u_pick (
    .ptr_i   (rr_q),
    .mask_i  (ch_en),
    .grant_o (grant),
    .any_o   (any_en)
  );

  always_comb begin
    hold     = (state_q == HOLD);
    fire     = hold & out_ready[sel_q];
    rr       = (mode_e'(mode) == MODE_RR);
    route_ok = rr ? any_en : 1'b1;
    in_ready = (~hold | fire) & route_ok;
    load     = in_valid & in_ready;
    dest     = rr ? grant : in_dest;
    dropped  = load & ~rr & ~ch_en[in_dest];
    accept   = load & ~dropped;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    vld_d   = vld_q;
    rr_d    = rr_q;
    drop_d  = dropped;
    if (accept) begin
      state_d = HOLD;
      sel_d   = dest;
      data_d  = in_data;
      vld_d   = 4'b0001 << dest;
      if (rr) rr_d = dest;
    end else if (fire) begin
      state_d = IDLE;
      vld_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      vld_q   <= '0;
      rr_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      rr_q    <= rr_d;
      drop_q  <= drop_d;
    end
  end

  assign sel       = sel_q;
  assign out_data  = data_q;
  assign out_valid = vld_q;
  assign drop      = drop_q;

`ifdef DEMUX4_SCHED_STATS_EN
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stats_clr) begin
      cnt_q <= '0;
    end else if (fire && (cnt_q[sel_q] != {CNT_W{1'b1}})) begin
      cnt_q[sel_q] <= cnt_q[sel_q] + 1'b1;
    end
  end

  assign ch_count = cnt_q;
`endif

endmodule

// File: tb/tb_demux4_sched.sv
// Scoreboard bench for demux4_sched with a queue-based reference model.
// Build with DEMUX4_SCHED_STATS_EN to also exercise the counters.
module tb_demux4_sched;

  localparam int DW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mode = 1'b0;
  logic [3:0]    ch_en = 4'hF;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [1:0]    in_dest = '0;
  logic [1:0]    sel;
  logic [DW-1:0] out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready = 4'h0;
  logic          drop;
`ifdef DEMUX4_SCHED_STATS_EN
  logic          stats_clr = 1'b0;
  logic [4*CW-1:0] ch_count;
`endif

  demux4_sched #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .ch_en     (ch_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop      (drop)
`ifdef DEMUX4_SCHED_STATS_EN
    ,
    .stats_clr (stats_clr),
    .ch_count  (ch_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    ch;
    logic [DW-1:0] data;
  } beat_t;

  beat_t sb[$];
  int    drops[$];
  int    seen_ch[$];
  int    checks = 0;
  int    failures = 0;

  // Reference model: is a beat held, on which channel, and last RR grant.
  bit         m_busy = 0;
  logic [1:0] m_ch = '0;
  int         m_last = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit md, input logic [3:0] en, input bit v,
                       input logic [1:0] d, input logic [DW-1:0] dat,
                       input logic [3:0] ordy);
    bit         fire_m, exp_rdy, found;
    logic [1:0] dst;
    @(negedge clk);
    mode = md; ch_en = en; in_valid = v;
    in_dest = d; in_data = dat; out_ready = ordy;
    #1;
    fire_m  = m_busy && ordy[m_ch];
    exp_rdy = (!m_busy || fire_m) && (!md || en != 4'h0);
    check("in_ready", in_ready, exp_rdy);
    if (v && exp_rdy) begin
      dst = d;
      if (md) begin
        found = 0;
        for (int k = 1; k <= 4; k++) begin
          if (!found && en[(m_last + k) % 4]) begin
            dst = 2'((m_last + k) % 4);
            found = 1;
          end
        end
        m_last = int'(dst);
      end
      if (!md && !en[d]) begin
        drops.push_back(1);
        m_busy = 0;
      end else begin
        sb.push_back('{dst, dat});
        m_busy = 1;
        m_ch = dst;
      end
    end else if (fire_m) begin
      m_busy = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 4'hF, 0, 2'd0, '0, 4'hF);
  endtask

  // Monitor: pops an expected beat for every delivery the DUT presents.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (out_valid != 4'h0) begin
          check("onehot", out_valid, 4'b0001 << sel);
          if (out_ready[sel]) begin
            seen_ch.push_back(int'(sel));
            if (sb.size() == 0) begin
              checks++; failures++;
              $display("FAIL unexpected_beat actual=ch%0d/%0h required=none",
                       sel, out_data);
            end else begin
              e = sb.pop_front();
              check("sel", sel, e.ch);
              check("data", out_data, e.data);
            end
          end
        end
        if (drop) begin
          checks++;
          if (drops.size() == 0) begin
            failures++;
            $display("FAIL unexpected_drop actual=1 required=0 t=%0t", $time);
          end else begin
            void'(drops.pop_front());
          end
        end
      end
    end
  end

  int exp2[5] = '{1, 3, 0, 1, 3};

  initial begin
    #1;
    check("rst_valid", out_valid, 4'h0);
    check("rst_sel", sel, 2'd0);
    check("rst_drop", drop, 1'b0);
    check("rst_data", out_data, 8'h00);
    #11 rst_n = 1'b1;

    // Addressed back-to-back, no bubble
    cycle(0, 4'hF, 1, 2'd2, 8'hA1, 4'hF);
    cycle(0, 4'hF, 1, 2'd0, 8'hB2, 4'hF);
    check("t1_valid", out_valid, 4'b0100);
    cycle(0, 4'hF, 0, 2'd0, 8'h00, 4'hF);
    check("t1_valid2", out_valid, 4'b0001);
    check("t1_data2", out_data, 8'hB2);
    idle(2);

    // Round-robin over 1011
    seen_ch.delete();
    for (int i = 0; i < 5; i++) cycle(1, 4'b1011, 1, 2'd2, 8'(8'h10 + i), 4'hF);
    idle(2);
    check("t2_count", seen_ch.size(), 5);
    for (int i = 0; i < 5 && i < seen_ch.size(); i++)
      check("t2_ch", seen_ch[i], exp2[i]);

    // Backpressure on ch3
    cycle(0, 4'hF, 1, 2'd3, 8'hC3, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 4'hF, 1, 2'd0, 8'h55, 4'b0001);
      check("t3_sel", sel, 2'd3);
      check("t3_data", out_data, 8'hC3);
    end
    cycle(0, 4'hF, 0, 2'd0, 8'h00, 4'b1000);
    cycle(0, 4'hF, 0, 2'd0, 8'h00, 4'hF);
    check("t3_idle", out_valid, 4'h0);

    // Drop to disabled channel, then RR with no channels
    cycle(0, 4'b1110, 1, 2'd0, 8'hD4, 4'hF);
    cycle(0, 4'b1110, 0, 2'd0, 8'h00, 4'hF);
    check("t4_drop", drop, 1'b1);
    check("t4_valid", out_valid, 4'h0);
    cycle(1, 4'h0, 1, 2'd0, 8'h77, 4'hF);
    idle(1);
    check("t4_nodrop", drop, 1'b0);

    // Asynchronous reset while holding
    cycle(0, 4'hF, 1, 2'd1, 8'hE5, 4'h0);
    cycle(0, 4'hF, 0, 2'd0, 8'h00, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_valid", out_valid, 4'h0);
    check("t5_sel", sel, 2'd0);
    sb.delete(); drops.delete();
    m_busy = 0; m_last = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    seen_ch.delete();
    cycle(1, 4'hF, 1, 2'd3, 8'hF6, 4'hF);
    idle(2);
    check("t5_count", seen_ch.size(), 1);
    if (seen_ch.size() > 0) check("t5_first_rr", seen_ch[0], 1);

`ifdef DEMUX4_SCHED_STATS_EN
    stats_clr = 1'b1;
    idle(1);
    stats_clr = 1'b0;
    for (int i = 0; i < 4; i++) cycle(0, 4'hF, 1, 2'd2, 8'(i), 4'hF);
    idle(2);
    check("t6_sat", ch_count[5:4], 2'd3);
    check("t6_ch0", ch_count[1:0], 2'd0);
    cycle(0, 4'hF, 1, 2'd2, 8'h99, 4'hF);
    cycle(0, 4'hF, 0, 2'd0, 8'h00, 4'hF);
    stats_clr = 1'b1;
    @(posedge clk);
    #1 stats_clr = 1'b0;
    check("t6_clr", ch_count[5:4], 2'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom % 2),
            ($urandom % 4 == 0) ? 4'($urandom) : 4'hF,
            1'($urandom % 4 != 0),
            2'($urandom), 8'($urandom), 4'($urandom));
    end
    idle(4);
    check("end_sb_empty", sb.size(), 0);
    check("end_drops_empty", drops.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
